// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : funct3 size codes, FSM state encoding, funct3 legality  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align : load extraction/extension and sub-word store merge    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_store_word
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halves use offset[1] only and words ignore the offset, so misaligned
  // accesses are force-aligned when they are not trapped upstream.
  always_comb begin
    w_bsh        = {i_offset, 3'b000};
    w_hsh        = {i_offset[1], 4'b0000};
    w_byte       = 8'(i_word >> w_bsh);
    w_half       = 16'(i_word >> w_hsh);
    o_load_val   = '0;
    o_store_word = i_word;
    case (i_funct3)
      F3_B: begin
        o_load_val   = {{24{w_byte[7]}}, w_byte};
        o_store_word = (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'h0, i_wdata[7:0]} << w_bsh);
      end
      F3_H: begin
        o_load_val   = {{16{w_half[15]}}, w_half};
        o_store_word = (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'h0, i_wdata[15:0]} << w_hsh);
      end
      F3_W: begin
        o_load_val   = i_word;
        o_store_word = i_wdata;
      end
      F3_BU:   o_load_val = {24'h0, w_byte};
      F3_HU:   o_load_val = {16'h0, w_half};
      default: o_load_val = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_lsu_ctrl : RV32 load/store sequencer for word memory     |
// | Option macro: LSU_MISALIGN_TRAP_EN (fault misaligned H/W access)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module data_mem_lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 21
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              store_q, store_d;
  logic              fault_q, fault_d;

  logic              w_accept;
  logic              w_oor;
  logic              w_misalign;
  logic              w_fault;
  logic [31:0]       w_align_word;
  logic [31:0]       w_load_val;
  logic [31:0]       w_store_word;

  assign req_ready = (state_q == S_IDLE) && !RST;
  assign w_accept  = req_valid && req_ready;
  assign w_oor     = {2'b00, req_addr[ADDR_W-1:2]} >= c_mem_words;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault      = !f3_legal(req_store, req_funct3) || w_oor || w_misalign;
  assign w_align_word = (state_q == S_WRITE) ? word_q : mem_dout;

  lsu_align u_align (
    .i_word       (w_align_word),
    .i_offset     (addr_q[1:0]),
    .i_funct3     (f3_q),
    .i_wdata      (wdata_q),
    .o_load_val   (w_load_val),
    .o_store_word (w_store_word)
  );

  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_fault = resp_valid && fault_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    f3_d     = f3_q;
    store_d  = store_q;
    fault_d  = fault_q;
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          store_d = req_store;
          fault_d = w_fault;
          rdata_d = '0;
          state_d = w_fault ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (!store_q) begin
          rdata_d = w_load_val;
          state_d = S_RESP;
        end else if (f3_q == F3_W) begin
          mem_rw  = 1'b1;
          mem_din = wdata_q;
          state_d = S_RESP;
        end else begin
          // Sub-word store: read the word now, write the merged word next cycle.
          word_d  = mem_dout;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_en   = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        mem_din  = w_store_word;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      fault_q <= fault_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_mem_lsu_ctrl : directed + random bench with memory model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_data_mem_lsu_ctrl;

  localparam int MEM_WORDS = 21;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic        mem_init = 1'b1;
  int          wr_count = 0;
  logic        bad_mem  = 1'b0;

  always #5 CLK = ~CLK;

  data_mem_lsu_ctrl #(.ADDR_W(32), .MEM_WORDS(MEM_WORDS)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Word memory: combinational read, write on posedge.
  assign mem_dout = (mem_en && ((mem_addr >> 2) < 32'(MEM_WORDS))) ? mem[mem_addr[6:2]] : 32'h0;

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h9E37_79B9 * 32'(i + 1);
    end else if (mem_en && mem_rw) begin
      if (((mem_addr >> 2) < 32'(MEM_WORDS)) && (mem_addr[1:0] == 2'b00)) mem[mem_addr[6:2]] <= mem_din;
      wr_count <= wr_count + 1;
    end
    if (mem_en && (((mem_addr >> 2) >= 32'(MEM_WORDS)) || (mem_addr[1:0] != 2'b00))) bad_mem <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one request, from the ISA rules.
  task automatic ref_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output int wr);
    logic legal;
    logic [31:0] w, v;
    int idx, bp, hp, sz;
    sz    = int'(f3[1:0]);
    legal = st ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    flt   = !legal || ((addr / 4) >= 32'(MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 1 && (addr % 2) != 0) flt = 1'b1;
    if (sz == 2 && (addr % 4) != 0) flt = 1'b1;
`endif
    rd  = 32'h0;
    wr  = 0;
    lat = 1;
    if (!flt) begin
      idx = int'(addr / 4);
      w   = ref_mem[idx];
      bp  = int'(addr % 4);
      hp  = (bp / 2) * 2;
      if (!st) begin
        lat = 2;
        case (sz)
          0: begin
            v = (w >> (8 * bp)) & 32'hFF;
            if (f3 < 3'd4 && v >= 32'd128) v = v + 32'hFFFF_FF00;
          end
          1: begin
            v = (w >> (8 * hp)) & 32'hFFFF;
            if (f3 < 3'd4 && v >= 32'd32768) v = v + 32'hFFFF_0000;
          end
          default: v = w;
        endcase
        rd = v;
      end else begin
        wr = 1;
        case (sz)
          0: begin
            ref_mem[idx] = (w & ~(32'hFF << (8 * bp))) | ((wd & 32'hFF) << (8 * bp));
            lat = 3;
          end
          1: begin
            ref_mem[idx] = (w & ~(32'hFFFF << (8 * hp))) | ((wd & 32'hFFFF) << (8 * hp));
            lat = 3;
          end
          default: begin
            ref_mem[idx] = wd;
            lat = 2;
          end
        endcase
      end
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    logic [31:0] e_rdata;
    logic        e_fault;
    int          e_lat, e_wr, lat, n, wr0;
    ref_op(st, f3, addr, wd, e_rdata, e_fault, e_lat, e_wr);
    @(negedge CLK);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    wr0 = wr_count;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("rdata", resp_rdata, e_rdata);
    check("fault", 32'(resp_fault), 32'(e_fault));
    check("mem_writes", 32'(wr_count - wr0), 32'(e_wr));
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, e_rdata);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge CLK);
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h9E37_79B9 * 32'(i + 1);

    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_rw", 32'(mem_rw), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    RST      = 1'b0;
    mem_init = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Directed sequences
    do_req(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 0);
    check("sw_word2", mem[2], 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h04, 32'h1122_3344, 0);
    do_req(1'b1, 3'b000, 32'h05, 32'h0000_00AB, 0);
    check("sb_word1", mem[1], 32'h1122_AB44);
    do_req(1'b0, 3'b000, 32'h05, 32'h0, 0);
    do_req(1'b0, 3'b100, 32'h05, 32'h0, 0);
    do_req(1'b1, 3'b001, 32'h06, 32'h0000_8001, 0);
    check("sh_word1", mem[1], 32'h8001_AB44);
    do_req(1'b0, 3'b001, 32'h06, 32'h0, 0);
    do_req(1'b0, 3'b101, 32'h06, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h54, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h50, 32'h0, 0);
    do_req(1'b0, 3'b011, 32'h08, 32'h0, 0);
    do_req(1'b1, 3'b100, 32'h08, 32'h5555_5555, 0);
    do_req(1'b1, 3'b010, 32'h54, 32'h7777_7777, 0);
    do_req(1'b0, 3'b010, 32'h02, 32'h0, 0);
    do_req(1'b0, 3'b001, 32'h07, 32'h0, 0);

    // Backpressure
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 5);

    // Reset during ACCESS
    @(negedge CLK);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("mid_access_en", 32'(mem_en), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 95));
      do_req(st, f3, a, $urandom, 0);
    end

    for (int i = 0; i < MEM_WORDS; i++) check("final_mem", mem[i], ref_mem[i]);
    check("mem_bus_legal", 32'(bad_mem), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
